// File: rtl/i2s_rx_pkg.sv
// Shared definitions for the I2S receive path: sample width, bit-counter width
// and the word-select channel encoding.
package i2s_rx_pkg;

    localparam int I2S_WIDTH = 16;
    localparam int I2S_CNT_W = 6;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } chan_e;

endpackage

// File: rtl/i2s_rx_edge_sync.sv
// Two-flop synchroniser for one codec-driven I2S line, with a registered
// rising-edge pulse taken from the synchroniser stages.
module i2s_edge_sync
    import i2s_rx_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o
);

    logic [1:0] sync_q;
    logic       rise_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], async_i};
            rise_q <= sync_q[0] & ~sync_q[1];
        end
    end

    assign sync_o = sync_q[1];
    assign rise_o = rise_q;

endmodule

// File: rtl/i2s_rx.sv
// I2S slave receiver: oversamples sclk/lrclk/dout in the clk domain, assembles
// left/right words and presents complete stereo frames on a valid/ready port.
module i2s_rx
    import i2s_rx_pkg::*;
#(
    parameter int WIDTH = I2S_WIDTH,
    parameter int CNT_W = I2S_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i2s_sclk,
    input  logic             i2s_lrclk,
    input  logic             i2s_dout,
    output logic [WIDTH-1:0] out_left,
    output logic [WIDTH-1:0] out_right,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    output logic             frame_err
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic sclk_rise, lrclk_s, dout_s;
    logic sclk_lvl_unused, lrclk_rise_unused, dout_rise_unused;

    // The three pipelines are identical, so lrclk_s/dout_s line up with sclk_rise.
    i2s_edge_sync u_sync_sclk (
        .clk     (clk),
        .rst     (rst),
        .async_i (i2s_sclk),
        .sync_o  (sclk_lvl_unused),
        .rise_o  (sclk_rise)
    );

    i2s_edge_sync u_sync_lrclk (
        .clk     (clk),
        .rst     (rst),
        .async_i (i2s_lrclk),
        .sync_o  (lrclk_s),
        .rise_o  (lrclk_rise_unused)
    );

    i2s_edge_sync u_sync_dout (
        .clk     (clk),
        .rst     (rst),
        .async_i (i2s_dout),
        .sync_o  (dout_s),
        .rise_o  (dout_rise_unused)
    );

    chan_e            w_q, w_d, lr_ch;
    logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] left_hold_q, left_hold_d;
    logic             left_arm_q, left_arm_d;
    logic             left_ok_q, left_ok_d;
    logic [WIDTH-1:0] out_left_q, out_left_d;
    logic [WIDTH-1:0] out_right_q, out_right_d;
    logic             out_valid_q, out_valid_d;
    logic             overrun_q, overrun_d;
    logic             frame_err_q, frame_err_d;
    logic [WIDTH-1:0] word;
    logic             frame_done;

    assign lr_ch = chan_e'(lrclk_s);

    always_comb begin
        w_d         = w_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        left_hold_d = left_hold_q;
        left_arm_d  = left_arm_q;
        left_ok_d   = left_ok_q;
        out_left_d  = out_left_q;
        out_right_d = out_right_q;
        out_valid_d = out_valid_q;
        overrun_d   = 1'b0;
        frame_err_d = 1'b0;
        frame_done  = 1'b0;
        word        = {shift_q[WIDTH-2:0], dout_s};

        if (sclk_rise) begin
            // A channel change consumes this edge: it carries the one-bit I2S delay.
            if (lr_ch != w_q) begin
                if (bitcnt_q != '0 && bitcnt_q < FULL) begin
                    frame_err_d = 1'b1;
                end
                bitcnt_d = '0;
                w_d      = lr_ch;
                if (lr_ch == CH_LEFT) begin
                    left_arm_d = 1'b1;
                end
            end else if (bitcnt_q < FULL) begin
                shift_d  = word;
                bitcnt_d = bitcnt_q + CNT_W'(1);
                if (bitcnt_q == LAST) begin
                    if (w_q == CH_LEFT && left_arm_q) begin
                        left_hold_d = word;
                        left_ok_d   = 1'b1;
                        left_arm_d  = 1'b0;
                    end else if (w_q == CH_RIGHT && left_ok_q) begin
                        frame_done  = 1'b1;
                        left_ok_d   = 1'b0;
                    end
                end
            end
        end

        // Single-entry holding register; a frame arriving while it is full and not
        // being drained is dropped so the presented frame never changes under stall.
        if (frame_done) begin
            if (!out_valid_q || out_ready) begin
                out_left_d  = left_hold_q;
                out_right_d = word;
                out_valid_d = 1'b1;
            end else begin
                overrun_d   = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_q         <= CH_LEFT;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            left_hold_q <= '0;
            left_arm_q  <= 1'b0;
            left_ok_q   <= 1'b0;
            out_left_q  <= '0;
            out_right_q <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            w_q         <= w_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            left_hold_q <= left_hold_d;
            left_arm_q  <= left_arm_d;
            left_ok_q   <= left_ok_d;
            out_left_q  <= out_left_d;
            out_right_q <= out_right_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign out_left  = out_left_q;
    assign out_right = out_right_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: drives I2S slots, predicts frames/errors per slot
// and compares every cycle, with literal expectations after each scenario.
module tb_i2s_rx;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst, sclk, lrclk, dout, outReady;
    logic [W-1:0]  outLeft, outRight;
    logic          outValid, overrun, frameErr;

    i2s_rx #(.WIDTH(16), .CNT_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .i2s_sclk  (sclk),
        .i2s_lrclk (lrclk),
        .i2s_dout  (dout),
        .out_left  (outLeft),
        .out_right (outRight),
        .out_valid (outValid),
        .out_ready (outReady),
        .overrun   (overrun),
        .frame_err (frameErr)
    );

    always #5 clk = ~clk;

    typedef struct {
        time          due;
        bit           isErr;
        logic [15:0]  l;
        logic [15:0]  r;
    } evT;

    evT evq[$];

    int checks = 0, fails = 0;
    int handCount = 0, errPulses = 0, ovPulses = 0;
    logic [15:0] handL = '0, handR = '0;

    bit mCh, mArm, mOk;
    int mBits, mVal, mLeft;

    logic [15:0] eL, eR;
    bit eValid, eErr, eOv;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mCh   = 1'b0;
        mArm  = 1'b0;
        mOk   = 1'b0;
        mBits = 0;
        mVal  = 0;
        mLeft = 0;
    endtask

    // Slot-level rules: a change costs one delay bit, the first W bits after it
    // form the word, a right word only makes a frame after a properly started left.
    task automatic modelRise(input bit lr, input bit d, input time t);
        if (lr != mCh) begin
            if (mBits > 0 && mBits < W) evq.push_back('{t + 25, 1'b1, 16'h0, 16'h0});
            mBits = 0;
            mVal  = 0;
            mCh   = lr;
            if (!lr) mArm = 1'b1;
        end else if (mBits < W) begin
            mVal = (mVal * 2 + int'(d)) % 65536;
            mBits++;
            if (mBits == W) begin
                if (!mCh && mArm) begin
                    mLeft = mVal;
                    mOk   = 1'b1;
                    mArm  = 1'b0;
                end else if (mCh && mOk) begin
                    evq.push_back('{t + 25, 1'b0, 16'(mLeft), 16'(mVal)});
                    mOk = 1'b0;
                end
            end
        end
    endtask

    // One slot of n sclk periods; data is left-aligned, the first bit is the delay bit.
    task automatic applyStimulus(input bit lr, input int n, input logic [31:0] data, input int rstAt);
        for (int i = 0; i < n; i++) begin
            bit d;
            d     = (i == 0) ? 1'b1 : data[32 - i];
            sclk  = 1'b0;
            lrclk = lr;
            dout  = d;
            if (i == rstAt) begin
                #10;
                rst = 1'b1;
                modelReset();
                #10;
                rst = 1'b0;
                #20;
            end else begin
                #40;
            end
            sclk = 1'b1;
            modelRise(lr, d, $time);
            #40;
        end
    endtask

    task automatic sendFrame(input logic [15:0] l, input logic [15:0] r, input logic [15:0] extra);
        applyStimulus(1'b0, 32, {l, extra}, -1);
        applyStimulus(1'b1, 32, {r, extra}, -1);
    endtask

    // Per-cycle compare two time units after each rising clock edge.
    task automatic compareStep();
        time edgeT;
        bit gotFrame;
        logic [15:0] fL, fR;
        edgeT    = $time - 2;
        gotFrame = 1'b0;
        fL       = '0;
        fR       = '0;
        if (rst) begin
            eValid = 1'b0;
            eL     = '0;
            eR     = '0;
            eErr   = 1'b0;
            eOv    = 1'b0;
            evq.delete();
        end else begin
            eErr = 1'b0;
            eOv  = 1'b0;
            for (int i = evq.size() - 1; i >= 0; i--) begin
                if (evq[i].due == edgeT) begin
                    if (evq[i].isErr) begin
                        eErr = 1'b1;
                    end else begin
                        gotFrame = 1'b1;
                        fL = evq[i].l;
                        fR = evq[i].r;
                    end
                    evq.delete(i);
                end
            end
            if (gotFrame) begin
                if (!eValid || outReady) begin
                    eL     = fL;
                    eR     = fR;
                    eValid = 1'b1;
                end else begin
                    eOv = 1'b1;
                end
            end else if (eValid && outReady) begin
                eValid = 1'b0;
            end
            errPulses += int'(frameErr);
            ovPulses  += int'(overrun);
        end
        checkOutput("out_valid", 32'(outValid), 32'(eValid));
        checkOutput("out_left", 32'(outLeft), 32'(eL));
        checkOutput("out_right", 32'(outRight), 32'(eR));
        checkOutput("frame_err", 32'(frameErr), 32'(eErr));
        checkOutput("overrun", 32'(overrun), 32'(eOv));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            compareStep();
        end
    end

    // Handshakes are taken from pre-edge values, i.e. what the consumer accepts.
    always @(posedge clk) begin
        if (!rst && outValid && outReady) begin
            handCount++;
            handL = outLeft;
            handR = outRight;
        end
    end

    initial begin
        int hc0, er0, ov0;
        rst      = 1'b1;
        sclk     = 1'b0;
        lrclk    = 1'b1;
        dout     = 1'b0;
        outReady = 1'b1;
        modelReset();
        #40;
        rst = 1'b0;

        // Start inside a right slot, then a clean frame.
        applyStimulus(1'b1, 20, 32'hDEAD_BEEF, -1);
        sendFrame(16'h0001, 16'h8000, 16'h0000);
        checkOutput("startup_frames", 32'(handCount), 32'd1);
        checkOutput("startup_left", 32'(handL), 32'h0001);
        checkOutput("startup_right", 32'(handR), 32'h8000);
        checkOutput("startup_no_err", 32'(errPulses), 32'd0);

        hc0 = handCount;
        sendFrame(16'hA55A, 16'h1234, 16'h0000);
        sendFrame(16'hA55A, 16'h1234, 16'h0000);
        checkOutput("nominal_frames", 32'(handCount - hc0), 32'd2);
        checkOutput("nominal_left", 32'(handL), 32'hA55A);
        checkOutput("nominal_right", 32'(handR), 32'h1234);

        ov0 = ovPulses;
        outReady = 1'b0;
        sendFrame(16'h1111, 16'h2222, 16'h0000);
        sendFrame(16'h3333, 16'h4444, 16'h0000);
        checkOutput("bp_valid_held", 32'(outValid), 32'd1);
        checkOutput("bp_left_held", 32'(outLeft), 32'h1111);
        checkOutput("bp_right_held", 32'(outRight), 32'h2222);
        checkOutput("bp_overrun_once", 32'(ovPulses - ov0), 32'd1);
        outReady = 1'b1;
        #30;
        checkOutput("bp_valid_cleared", 32'(outValid), 32'd0);
        checkOutput("bp_drained_left", 32'(handL), 32'h1111);
        checkOutput("bp_drained_right", 32'(handR), 32'h2222);

        hc0 = handCount;
        er0 = errPulses;
        applyStimulus(1'b0, 32, {16'h1357, 16'h0000}, -1);
        applyStimulus(1'b1, 11, {16'h2468, 16'h0000}, -1);
        sendFrame(16'h00FF, 16'hFF00, 16'h0000);
        checkOutput("short_err_once", 32'(errPulses - er0), 32'd1);
        checkOutput("short_frames", 32'(handCount - hc0), 32'd1);
        checkOutput("short_next_left", 32'(handL), 32'h00FF);
        checkOutput("short_next_right", 32'(handR), 32'hFF00);

        er0 = errPulses;
        sendFrame(16'h0F0F, 16'h0F0F, 16'hFFFF);
        checkOutput("wide_left", 32'(handL), 32'h0F0F);
        checkOutput("wide_right", 32'(handR), 32'h0F0F);
        checkOutput("wide_no_err", 32'(errPulses - er0), 32'd0);

        outReady = 1'b0;
        sendFrame(16'h5A5A, 16'hA5A5, 16'h0000);
        checkOutput("rst_pre_valid", 32'(outValid), 32'd1);
        hc0 = handCount;
        applyStimulus(1'b0, 32, {16'h1111, 16'h0000}, 6);
        checkOutput("rst_valid_clear", 32'(outValid), 32'd0);
        checkOutput("rst_left_clear", 32'(outLeft), 32'h0000);
        checkOutput("rst_right_clear", 32'(outRight), 32'h0000);
        applyStimulus(1'b1, 32, {16'h7777, 16'h0000}, -1);
        outReady = 1'b1;
        sendFrame(16'hBEEF, 16'hCAFE, 16'h0000);
        checkOutput("rst_frames", 32'(handCount - hc0), 32'd1);
        checkOutput("rst_next_left", 32'(handL), 32'hBEEF);
        checkOutput("rst_next_right", 32'(handR), 32'hCAFE);

        #200;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
